// File: rtl/logic_unit_pkg.sv
// -----------------------------------------------------------------------------
// logic_unit_pkg
// Shared definitions for the logic unit: the 3-bit opcode type and its eight
// operation codes. Imported by logic_unit_core and logic_unit_pipe.
// -----------------------------------------------------------------------------
package logic_unit_pkg;

  localparam int unsigned OP_WIDTH = 3;

  // Every 3-bit code maps to an operation, so no code is left undefined.
  typedef enum logic [OP_WIDTH-1:0] {
    OP_NOT  = 3'd0,  // ~A
    OP_AND  = 3'd1,  // A & B
    OP_NAND = 3'd2,  // ~(A & B)
    OP_OR   = 3'd3,  // A | B
    OP_NOR  = 3'd4,  // ~(A | B)
    OP_XOR  = 3'd5,  // A ^ B
    OP_XNOR = 3'd6,  // ~(A ^ B)
    OP_PASS = 3'd7   // A
  } op_t;

endpackage : logic_unit_pkg

// File: rtl/logic_unit_core.sv
// -----------------------------------------------------------------------------
// logic_unit_core
// Purely combinational bitwise datapath.
// Ports:
//   a      in   DATA_WIDTH  effective operand A
//   b      in   DATA_WIDTH  operand B
//   op     in   3           operation select (op_t encoding)
//   result out  DATA_WIDTH  bitwise result
// -----------------------------------------------------------------------------
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [OP_WIDTH-1:0]   op,
  output logic [DATA_WIDTH-1:0] result
);

  always_comb begin
    // NOTE: assign a default before the case so no path leaves result unassigned (no latch).
    result = '0;
    unique case (op_t'(op))
      OP_NOT:  result = ~a;
      OP_AND:  result = a & b;
      OP_NAND: result = ~(a & b);
      OP_OR:   result = a | b;
      OP_NOR:  result = ~(a | b);
      OP_XOR:  result = a ^ b;
      OP_XNOR: result = ~(a ^ b);
      OP_PASS: result = a;
      default: result = '0;
    endcase
  end

endmodule : logic_unit_core

// File: rtl/logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe
// Single-stage valid/ready pipeline around logic_unit_core. Holds the output
// register (result, zero flag, parity), an accumulator that captures every
// accepted result, and a wrapping count of accepted transactions.
// Ports:
//   clk            in   1           clock, rising edge
//   rst            in   1           synchronous active-high reset
//   in_valid       in   1           upstream offers a transaction
//   in_ready       out  1           transaction accepted this cycle if in_valid
//   a_in, b_in     in   DATA_WIDTH  operands
//   op_in          in   3           operation select
//   acc_sel_in     in   1           1 = accumulator replaces a_in as operand A
//   out_valid      out  1           output register holds a result
//   out_ready      in   1           downstream takes the result
//   result_out     out  DATA_WIDTH  registered result
//   zero_out       out  1           registered result == 0
//   parity_out     out  1           registered XOR-reduce of result
//   txn_count_out  out  CNT_WIDTH   accepted-transaction count (wraps)
// -----------------------------------------------------------------------------
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic [OP_WIDTH-1:0]   op_in,
  input  logic                  acc_sel_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result_out,
  output logic                  zero_out,
  output logic                  parity_out,
  output logic [CNT_WIDTH-1:0]  txn_count_out
);

  logic [DATA_WIDTH-1:0] acc_q;
  logic [DATA_WIDTH-1:0] eff_a;
  logic [DATA_WIDTH-1:0] core_result;
  logic                  accept;

  // The output stage can take a new result when empty or being drained this
  // cycle, so continuous flow runs without bubbles.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // The accumulator register is updated on the same edge as the accept, so a
  // back-to-back accept already sees the previous result here.
  assign eff_a = acc_sel_in ? acc_q : a_in;

  logic_unit_core #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_core (
    .a      (eff_a),
    .b      (b_in),
    .op     (op_in),
    .result (core_result)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      out_valid     <= 1'b0;
      result_out    <= '0;
      zero_out      <= 1'b1;   // consistent with the cleared result
      parity_out    <= 1'b0;
      acc_q         <= '0;
      txn_count_out <= '0;
    end else if (accept) begin
      // Accept covers the simultaneous drain-and-load case: out_valid stays 1.
      out_valid     <= 1'b1;
      result_out    <= core_result;
      zero_out      <= ~|core_result;
      parity_out    <= ^core_result;
      acc_q         <= core_result;
      txn_count_out <= txn_count_out + CNT_WIDTH'(1);
    end else if (out_valid && out_ready) begin
      // Drain with no replacement; the stale result may stay in the register.
      out_valid <= 1'b0;
    end
  end

endmodule : logic_unit_pipe

// File: tb/tb_logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// tb_logic_unit_pipe
// Directed testbench for logic_unit_pipe (DATA_WIDTH=4). A second instance with
// CNT_WIDTH=2 shares all inputs to observe counter wrap-around.
// -----------------------------------------------------------------------------
module tb_logic_unit_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready, in_ready_w;
  logic [3:0] a_in, b_in;
  logic [2:0] op_in;
  logic       acc_sel_in;
  logic       out_valid, out_valid_w;
  logic       out_ready;
  logic [3:0] result_out, result_w;
  logic       zero_out, zero_w;
  logic       parity_out, parity_w;
  logic [7:0] txn_count_out;
  logic [1:0] txn_count_w;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  logic_unit_pipe #(.DATA_WIDTH(4), .CNT_WIDTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .a_in          (a_in),
    .b_in          (b_in),
    .op_in         (op_in),
    .acc_sel_in    (acc_sel_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result_out    (result_out),
    .zero_out      (zero_out),
    .parity_out    (parity_out),
    .txn_count_out (txn_count_out)
  );

  logic_unit_pipe #(.DATA_WIDTH(4), .CNT_WIDTH(2)) dut_w (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready_w),
    .a_in          (a_in),
    .b_in          (b_in),
    .op_in         (op_in),
    .acc_sel_in    (acc_sel_in),
    .out_valid     (out_valid_w),
    .out_ready     (out_ready),
    .result_out    (result_w),
    .zero_out      (zero_w),
    .parity_out    (parity_w),
    .txn_count_out (txn_count_w)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the full output register contents in one call.
  task automatic check_out(input string tag, input logic v, input logic [3:0] r,
                           input logic z, input logic p, input logic [7:0] c);
    check({tag, ".valid"},  {31'd0, out_valid},  {31'd0, v});
    check({tag, ".result"}, {28'd0, result_out}, {28'd0, r});
    check({tag, ".zero"},   {31'd0, zero_out},   {31'd0, z});
    check({tag, ".parity"}, {31'd0, parity_out}, {31'd0, p});
    check({tag, ".count"},  {24'd0, txn_count_out}, {24'd0, c});
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] op, input logic sel);
    a_in       = a;
    b_in       = b;
    op_in      = op;
    acc_sel_in = sel;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive(4'b0000, 4'b0000, 3'd7, 1'b0);
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    #1;

    // Reset state and ready after release.
    check_out("reset", 1'b0, 4'b0000, 1'b1, 1'b0, 8'd0);
    check("reset.in_ready", {31'd0, in_ready}, 32'd1);

    // Operation sweep with continuous flow (out_ready=1).
    in_valid = 1'b1;
    drive(4'b1100, 4'b1010, 3'd1, 1'b0); step();
    check_out("and",  1'b1, 4'b1000, 1'b0, 1'b1, 8'd1);
    drive(4'b1111, 4'b0000, 3'd4, 1'b0); step();
    check_out("nor",  1'b1, 4'b0000, 1'b1, 1'b0, 8'd2);
    drive(4'b0101, 4'b0000, 3'd0, 1'b0); step();
    check_out("not",  1'b1, 4'b1010, 1'b0, 1'b0, 8'd3);
    drive(4'b1100, 4'b1010, 3'd6, 1'b0); step();
    check_out("xnor", 1'b1, 4'b1001, 1'b0, 1'b0, 8'd4);
    drive(4'b1100, 4'b1010, 3'd2, 1'b0); step();
    check_out("nand", 1'b1, 4'b0111, 1'b0, 1'b1, 8'd5);
    drive(4'b1100, 4'b1010, 3'd3, 1'b0); step();
    check_out("or",   1'b1, 4'b1110, 1'b0, 1'b1, 8'd6);
    drive(4'b0011, 4'b1111, 3'd7, 1'b0); step();
    check_out("pass", 1'b1, 4'b0011, 1'b0, 1'b0, 8'd7);
    drive(4'b1100, 4'b1010, 3'd5, 1'b0); step();
    check_out("xor",  1'b1, 4'b0110, 1'b0, 1'b0, 8'd8);

    // Drain with no new transaction: valid drops, count unchanged.
    in_valid = 1'b0; step();
    check("drain.valid", {31'd0, out_valid}, 32'd0);
    check("drain.count", {24'd0, txn_count_out}, 32'd8);

    // Backpressure: only one accept while out_ready=0.
    out_ready = 1'b0; in_valid = 1'b1;
    drive(4'b0001, 4'b1111, 3'd1, 1'b0); step();
    check_out("bp.first", 1'b1, 4'b0001, 1'b0, 1'b1, 8'd9);
    drive(4'b1111, 4'b0011, 3'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("bp.in_ready", {31'd0, in_ready}, 32'd0);
      step();
      check_out("bp.hold", 1'b1, 4'b0001, 1'b0, 1'b1, 8'd9);
    end
    out_ready = 1'b1; #1;
    check("bp.release_ready", {31'd0, in_ready}, 32'd1);
    step();
    check_out("bp.next", 1'b1, 4'b1111, 1'b0, 1'b0, 8'd10);
    check("wrap.count_mid", {30'd0, txn_count_w}, 32'd2);

    // Reset while a result is held under backpressure.
    out_ready = 1'b0; step();
    check("rst_hold.valid_pre", {31'd0, out_valid}, 32'd1);
    rst = 1'b1; step();
    rst = 1'b0;
    check_out("rst_hold", 1'b0, 4'b0000, 1'b1, 1'b0, 8'd0);

    // Accumulator chain from reset: acc starts at 0.
    out_ready = 1'b1;
    drive(4'b1111, 4'b0101, 3'd5, 1'b1); step();
    check_out("acc1", 1'b1, 4'b0101, 1'b0, 1'b0, 8'd1);
    step();
    check_out("acc2", 1'b1, 4'b0000, 1'b1, 1'b0, 8'd2);
    drive(4'b1111, 4'b0011, 3'd5, 1'b1); step();
    check_out("acc3", 1'b1, 4'b0011, 1'b0, 1'b0, 8'd3);

    // Two more accepts: 5 total, the 2-bit counter wraps to 1.
    drive(4'b0010, 4'b0000, 3'd7, 1'b0); step();
    step();
    check("wrap.count_w", {30'd0, txn_count_w}, 32'd1);
    check("wrap.count",   {24'd0, txn_count_out}, 32'd5);
    check("wrap.result_w", {28'd0, result_w}, 32'd2);

    // Idle: no state change without in_valid once drained.
    in_valid = 1'b0; step(); step();
    check_out("idle", 1'b0, 4'b0010, 1'b0, 1'b1, 8'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_logic_unit_pipe
